ref_row_loader: RTL and testbench



---
 rtl/interp_pkg.sv | 13 +
 rtl/ref_row_loader.sv | 78 +++++++
 tb/tb_ref_row_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/interp_pkg.sv
// interp_pkg: shared state encoding, beat/pixel widths and row-width helper for the interpolation loader
package interp_pkg;

    localparam int BEAT_W = 64;
    localparam int PIX_W  = 8;

    typedef enum logic [2:0] {IDLE, LO, HI, PUSH, DONE} state_t;

    function automatic int ROW_W(input int pix);
        return pix * PIX_W;
    endfunction

endpackage

// File: rtl/ref_row_loader.sv
// ref_row_loader: packs pairs of 64-bit beats into PIX-pixel rows and strobes them into the shift register.
// Optional LOADER_STALL_CNT_EN adds a 64-bit stall_cnt of LO/HI cycles without in_valid.
module ref_row_loader
    import interp_pkg::*;
#(
    parameter int ROWS = 15,
    parameter int PIX  = 15
) (
    input  logic                    clock,
    input  logic                    reset_L,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [BEAT_W-1:0]       in_data,
    output logic                    in_ready,
    output logic [ROW_W(PIX)-1:0]   row_out,
    output logic                    load_L,
    output logic                    busy,
    output logic                    done
`ifdef LOADER_STALL_CNT_EN
    ,
    output logic [63:0]             stall_cnt
`endif
);

    localparam int RW = ROW_W(PIX);

    state_t     state, state_nx;
    logic [3:0] row_cnt;
    logic       last, take;

    assign last = row_cnt == 4'(ROWS - 1);
    assign take = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset_L)
        if (!reset_L) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? LO : IDLE;
            LO:      state_nx = in_valid ? HI : LO;
            HI:      state_nx = in_valid ? PUSH : HI;
            PUSH:    state_nx = last ? DONE : LO;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = state == LO || state == HI;
        busy     = state != IDLE;
        done     = state == DONE;
    end

    // load_L is registered off the next state so it is low exactly while in PUSH
    always_ff @(posedge clock or negedge reset_L)
        if (!reset_L) begin
            row_cnt <= '0;
            row_out <= '0;
            load_L  <= 1'b1;
        end else begin
            load_L <= state_nx != PUSH;
            if (state == IDLE && start) row_cnt <= '0;
            else if (state == PUSH && !last) row_cnt <= row_cnt + 4'd1;
            if (take && state == LO) row_out <= {row_out[RW-1:BEAT_W], in_data};
            // upper beat bytes beyond the row width fall off in the truncation
            if (take && state == HI) row_out <= RW'({in_data, row_out[BEAT_W-1:0]});
        end

`ifdef LOADER_STALL_CNT_EN
    always_ff @(posedge clock or negedge reset_L)
        if (!reset_L) stall_cnt <= '0;
        else if (state == IDLE && start) stall_cnt <= '0;
        else if (in_ready && !in_valid) stall_cnt <= stall_cnt + 64'd1;
`endif

endmodule

// File: tb/tb_ref_row_loader.sv
// tb_ref_row_loader: randomized scoreboard bench for ref_row_loader (default and ROWS=1/PIX=9 builds).
module tb_ref_row_loader;

    localparam int ROWS = 15;
    localparam int PIX  = 15;
    localparam int RW   = PIX * 8;

    logic          clock = 0, reset_L = 0, start = 0, in_valid = 0;
    logic [63:0]   in_data = '0;
    logic          in_ready, load_L, busy, done;
    logic [RW-1:0] row_out;
    logic          s_start = 0, s_valid = 0;
    logic [63:0]   s_data = '0;
    logic          s_ready, s_load_L, s_busy, s_done;
    logic [71:0]   s_row;
`ifdef LOADER_STALL_CNT_EN
    logic [63:0]   stall_cnt, s_stall;
`endif

    int            checks = 0, failures = 0, cyc = 0;
    logic [RW-1:0] exp_q[$];
    int            exp_stall[$];
    bit            prev_low = 0;
    int            loads = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    ref_row_loader #(.ROWS(ROWS), .PIX(PIX)) dut (
        .clock(clock), .reset_L(reset_L), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .row_out(row_out), .load_L(load_L), .busy(busy), .done(done)
`ifdef LOADER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    ref_row_loader #(.ROWS(1), .PIX(9)) dut1 (
        .clock(clock), .reset_L(reset_L), .start(s_start), .in_valid(s_valid), .in_data(s_data),
        .in_ready(s_ready), .row_out(s_row), .load_L(s_load_L), .busy(s_busy), .done(s_done)
`ifdef LOADER_STALL_CNT_EN
        , .stall_cnt(s_stall)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // pixel k comes from beat 0 for k<8, otherwise from byte k-8 of beat 1
    function automatic logic [RW-1:0] pack(input logic [63:0] b0, input logic [63:0] b1);
        logic [RW-1:0] r;
        for (int k = 0; k < PIX; k++) r[8*k +: 8] = k < 8 ? b0[8*k +: 8] : b1[8*(k-8) +: 8];
        return r;
    endfunction

    task automatic beat(input logic [63:0] d, input bit second, input logic [RW-1:0] e);
        int n = 0;
        in_valid = 1;
        in_data = d;
        while (!in_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("ready_wait", in_ready, 1);
        if (second && in_ready) exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic do_start(output int s);
        start = 1;
        @(posedge clock);
        #1 s = cyc;
        @(negedge clock);
        start = 0;
        chk("start_busy", busy, 1);
    endtask

    task automatic run_block(input int stall_row, input int stall_len, input int start_row,
                             input int rst_row, input bit dir0, input bit start_in_done);
        int s, n;
        logic [63:0] b0, b1;
        logic [RW-1:0] held;
        exp_stall.push_back(stall_len);
        do_start(s);
        for (int r = 0; r < ROWS; r++) begin
            b0 = (dir0 && r == 0) ? 64'h0706050403020100 : {$urandom, $urandom};
            b1 = (dir0 && r == 0) ? 64'hFF0E0D0C0B0A0908 : {$urandom, $urandom};
            if (r == start_row) start = 1;
            beat(b0, 0, '0);
            start = 0;
            if (r == rst_row) begin
                in_valid = 0;
                #2 reset_L = 0;
                #1;
                chk("rst_row_out", row_out, 0);
                chk("rst_load_L", load_L, 1);
                chk("rst_in_ready", in_ready, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
`ifdef LOADER_STALL_CNT_EN
                chk("rst_stall_cnt", stall_cnt, 0);
`endif
                exp_stall.delete();
                @(negedge clock);
                @(negedge clock);
                reset_L = 1;
                @(negedge clock);
                chk("rst_idle_busy", busy, 0);
                return;
            end
            if (r == stall_row) begin
                in_valid = 0;
                held = row_out;
                repeat (stall_len) begin
                    @(negedge clock);
                    chk("stall_row_hold", row_out, held);
                    chk("stall_no_load", load_L, 1);
                end
            end
            beat(b1, 1, pack(b0, b1));
            if (dir0 && r == 0) begin
                chk("first_row", row_out, 120'h0E0D0C0B0A09080706050403020100);
                chk("first_load_cycle", cyc - s, 2);
            end
        end
        n = 0;
        while (!done && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("done_cycle", cyc - s, 3 * ROWS + stall_len);
        if (start_in_done) start = 1;
        @(negedge clock);
        start = 0;
        chk("busy_after_done", busy, 0);
        chk("done_pulse_width", done, 0);
    endtask

    initial forever begin
        int es;
        logic [RW-1:0] e;
        @(negedge clock);
        if (!reset_L) begin
            loads = 0;
            prev_low = 0;
        end else begin
            if (!load_L) begin
                chk("load_single_cycle", prev_low, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL load_unexpected actual=load_L_low required=no_pulse");
                end else begin
                    e = exp_q.pop_front();
                    chk("row_out", row_out, e);
                end
                loads++;
            end
            prev_low = !load_L;
            if (done) begin
                chk("rows_per_block", loads, ROWS);
                loads = 0;
                es = exp_stall.size() != 0 ? exp_stall.pop_front() : -1;
`ifdef LOADER_STALL_CNT_EN
                chk("stall_cnt", stall_cnt, 64'(es));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [63:0] a, b;
        repeat (3) @(negedge clock);
        reset_L = 1;
        @(negedge clock);
        chk("reset_row_out", row_out, 0);
        chk("reset_load_L", load_L, 1);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
`ifdef LOADER_STALL_CNT_EN
        chk("reset_stall_cnt", stall_cnt, 0);
`endif
        run_block(-1, 0, -1, -1, 1, 0);
        run_block(7, 4, 3, -1, 0, 1);
        run_block(-1, 0, -1, 5, 0, 0);
        run_block(-1, 0, -1, -1, 0, 0);
        run_block($urandom_range(0, ROWS - 1), $urandom_range(1, 6), -1, -1, 0, 0);
        chk("queue_drained", exp_q.size(), 0);

        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        s_valid = 1;
        s_data = a;
        s_start = 1;
        @(negedge clock);
        s_start = 0;
        chk("r1_ready_lo", s_ready, 1);
        @(negedge clock);
        s_data = b;
        @(negedge clock);
        chk("r1_load_L", s_load_L, 0);
        chk("r1_top_pixel", s_row[71:64], b[7:0]);
        chk("r1_row", s_row, {b[7:0], a});
        @(negedge clock);
        chk("r1_done", s_done, 1);
        chk("r1_load_released", s_load_L, 1);
        @(negedge clock);
        chk("r1_idle", s_busy, 0);
        s_valid = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
